// File: rtl/memory_byte_sequencer_if.sv
// Request/response bus between the control unit and memory_byte_sequencer,
// plus the byte-wide RAM port the sequencer drives.
interface memory_byte_sequencer_if #(
    parameter int unsigned ADDR_W = 14
);
    logic              start;
    logic              write;
    logic [1:0]        size;
    logic [31:0]       Byte3;
    logic [31:0]       Byte2;
    logic [31:0]       Byte1;
    logic [31:0]       Byte0;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              busy;
    logic              done;
    logic              fault;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_we;
    logic [7:0]        mem_rdata;

    // Sequencer side: consumes requests and RAM read data.
    modport slave (
        input  start, write, size, Byte3, Byte2, Byte1, Byte0, wdata, mem_rdata,
        output rdata, busy, done, fault, mem_addr, mem_wdata, mem_we
    );

    // Environment side: control unit plus data RAM.
    modport master (
        output start, write, size, Byte3, Byte2, Byte1, Byte0, wdata, mem_rdata,
        input  rdata, busy, done, fault, mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/memory_byte_sequencer.sv
// Byte-serial load/store engine: takes one 32-bit request with four lane
// addresses and walks a byte-wide synchronous RAM one lane per cycle,
// lane 0 first. Faulting requests complete in one cycle without RAM access.
module memory_byte_sequencer #(
    parameter int unsigned ADDR_W = 14
) (
    input  logic                   clock,
    input  logic                   reset,
    memory_byte_sequencer_if.slave bus
);

    localparam logic [32:0] ADDR_LIMIT = 33'(1) << ADDR_W;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD,
        RD_DRAIN,
        FIN
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        idx_q, idx_d;     // lane currently on the RAM port
    logic [1:0]        last_q, last_d;   // final lane index (N-1)
    logic [31:0]       wdata_q, wdata_d;
    logic [ADDR_W-1:0] lane_addr_q [4];
    logic [ADDR_W-1:0] lane_addr_d [4];
    logic [31:0]       rdata_q, rdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              fault_q, fault_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic              mem_we_q, mem_we_d;

    logic [31:0]       req_byte [4];
    logic [1:0]        req_last;
    logic              req_fault;
    logic              accept;
    logic [1:0]        next_idx;
    logic [1:0]        cap_lane;

    // Lane address is unusable: empty-stack marker or beyond the RAM.
    function automatic logic lane_bad(input logic [31:0] a);
        return (a == 32'hFFFF_FFFF) || ({1'b0, a} >= ADDR_LIMIT);
    endfunction

    // Decode the incoming request: lane count and fault check on raw addresses.
    always_comb begin
        req_byte[0] = bus.Byte0;
        req_byte[1] = bus.Byte1;
        req_byte[2] = bus.Byte2;
        req_byte[3] = bus.Byte3;
        req_last    = 2'd0;
        req_fault   = 1'b0;
        case (bus.size)
            2'd0:    req_last = 2'd0;
            2'd1:    req_last = 2'd1;
            2'd2:    req_last = 2'd3;
            default: begin
                req_last  = 2'd0;
                req_fault = 1'b1;
            end
        endcase
        for (int unsigned k = 0; k < 4; k++) begin
            if ((2'(k) <= req_last) && lane_bad(req_byte[k])) begin
                req_fault = 1'b1;
            end
        end
    end

    // Next-state and registered-output logic; RAM port values are prepared
    // one cycle ahead so the port is driven straight from flops.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        last_d      = last_q;
        wdata_d     = wdata_q;
        lane_addr_d = lane_addr_q;
        rdata_d     = rdata_q;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        fault_d     = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        mem_we_d    = 1'b0;
        accept      = 1'b0;
        next_idx    = idx_q + 2'd1;
        cap_lane    = idx_q - 2'd1;

        case (state_q)
            IDLE, FIN: begin
                state_d = IDLE;
                accept  = bus.start;
            end
            WR: begin
                if (idx_q == last_q) begin
                    state_d = FIN;
                    done_d  = 1'b1;
                end else begin
                    idx_d       = next_idx;
                    busy_d      = 1'b1;
                    mem_addr_d  = lane_addr_q[next_idx];
                    mem_wdata_d = wdata_q[{next_idx, 3'b000} +: 8];
                    mem_we_d    = 1'b1;
                end
            end
            RD: begin
                // Read data trails its address by one cycle.
                if (idx_q != 2'd0) begin
                    rdata_d[{cap_lane, 3'b000} +: 8] = bus.mem_rdata;
                end
                busy_d = 1'b1;
                if (idx_q == last_q) begin
                    state_d = RD_DRAIN;
                end else begin
                    idx_d      = next_idx;
                    mem_addr_d = lane_addr_q[next_idx];
                end
            end
            RD_DRAIN: begin
                rdata_d[{last_q, 3'b000} +: 8] = bus.mem_rdata;
                state_d = FIN;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            if (req_fault) begin
                state_d = FIN;
                done_d  = 1'b1;
                fault_d = 1'b1;
            end else begin
                idx_d   = 2'd0;
                last_d  = req_last;
                wdata_d = bus.wdata;
                for (int unsigned k = 0; k < 4; k++) begin
                    lane_addr_d[k] = req_byte[k][ADDR_W-1:0];
                end
                busy_d     = 1'b1;
                mem_addr_d = req_byte[0][ADDR_W-1:0];
                if (bus.write) begin
                    state_d     = WR;
                    mem_we_d    = 1'b1;
                    mem_wdata_d = bus.wdata[7:0];
                end else begin
                    state_d = RD;
                    rdata_d = '0;
                end
            end
        end
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            last_q      <= '0;
            wdata_q     <= '0;
            lane_addr_q <= '{default: '0};
            rdata_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            last_q      <= last_d;
            wdata_q     <= wdata_d;
            lane_addr_q <= lane_addr_d;
            rdata_q     <= rdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            fault_q     <= fault_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
        end
    end

    assign bus.rdata     = rdata_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.fault     = fault_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_we    = mem_we_q;

endmodule

// File: tb/tb_memory_byte_sequencer.sv
// Bench for memory_byte_sequencer: byte RAM model plus a word-level
// reference model of loads, stores and faults.
module tb_memory_byte_sequencer;

    localparam int unsigned ADDR_W = 14;
    localparam int unsigned MEM_SZ = 1 << ADDR_W;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    memory_byte_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

    memory_byte_sequencer #(.ADDR_W(ADDR_W)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Synchronous byte RAM: read data valid the cycle after the address.
    logic [7:0] ram [MEM_SZ] = '{default: 8'h00};
    always @(posedge clk) begin
        if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= ram[bus.mem_addr];
    end

    // Reference model state.
    logic [7:0]        ref_mem [MEM_SZ] = '{default: 8'h00};
    logic [31:0]       exp_rdata = '0;
    logic              op_wr;
    logic [1:0]        op_sz;
    logic [31:0]       op_b [4];
    logic [31:0]       op_wd;
    int                exp_lat;
    logic              exp_fault;
    logic [21:0]       exp_wlog [$];
    logic [ADDR_W-1:0] exp_raddr [$];

    // Observations of one transaction.
    int                obs_done_cyc, obs_busy_cnt, obs_idle_err, obs_extra_done;
    logic              obs_fault;
    logic [31:0]       obs_rdata;
    logic [21:0]       obs_wlog [$];
    logic [ADDR_W-1:0] obs_raddr [$];

    function automatic logic [31:0] rand_addr();
        int unsigned r = $urandom_range(0, 39);
        if (r < 24) return 32'($urandom_range(0, 15));
        if (r < 36) return 32'(MEM_SZ - 16 + $urandom_range(0, 15));
        if (r == 36) return 32'hFFFF_FFFF;
        if (r == 37) return 32'(MEM_SZ + $urandom_range(0, 255));
        return $urandom | 32'h8000_0000;
    endfunction

    // Word-level model: lane count, fault rule, memory effect, latency.
    task automatic model_predict();
        int n;
        n = (op_sz == 2'd0) ? 1 : (op_sz == 2'd1) ? 2 : (op_sz == 2'd2) ? 4 : 0;
        exp_fault = (n == 0);
        for (int k = 0; k < n; k++)
            if (op_b[k] == 32'hFFFF_FFFF || op_b[k] >= MEM_SZ) exp_fault = 1'b1;
        exp_wlog.delete();
        exp_raddr.delete();
        if (exp_fault) begin
            exp_lat = 1;
            return;
        end
        if (op_wr) begin
            exp_lat = n + 1;
            for (int k = 0; k < n; k++) begin
                exp_wlog.push_back({op_b[k][ADDR_W-1:0], op_wd[8*k +: 8]});
                ref_mem[int'(op_b[k])] = op_wd[8*k +: 8];
            end
        end else begin
            exp_lat = n + 2;
            exp_rdata = '0;
            for (int k = 0; k < n; k++) begin
                exp_rdata[8*k +: 8] = ref_mem[int'(op_b[k])];
                exp_raddr.push_back(op_b[k][ADDR_W-1:0]);
            end
            exp_raddr.push_back('0);
        end
    endtask

    task automatic drive_req();
        bus.write = op_wr;
        bus.size  = op_sz;
        bus.Byte0 = op_b[0];
        bus.Byte1 = op_b[1];
        bus.Byte2 = op_b[2];
        bus.Byte3 = op_b[3];
        bus.wdata = op_wd;
        bus.start = 1'b1;
    endtask

    // Issue the current op in cycle 0 and record DUT activity until done+2.
    task automatic observe_op(input int pulse_cyc);
        obs_done_cyc = 0; obs_fault = 1'b0; obs_busy_cnt = 0; obs_idle_err = 0;
        obs_extra_done = 0; obs_rdata = '0;
        obs_wlog.delete();
        obs_raddr.delete();
        drive_req();
        for (int cyc = 1; cyc <= 24; cyc++) begin
            @(posedge clk); #1;
            bus.start = (cyc == pulse_cyc);
            if (cyc == 1) begin
                bus.write = 1'($urandom_range(0, 1));
                bus.size  = 2'($urandom_range(0, 3));
                bus.Byte0 = $urandom; bus.Byte1 = $urandom;
                bus.Byte2 = $urandom; bus.Byte3 = $urandom;
                bus.wdata = $urandom;
            end
            if (obs_done_cyc == 0) begin
                if (bus.busy) obs_busy_cnt++;
                if (bus.mem_we) obs_wlog.push_back({bus.mem_addr, bus.mem_wdata});
                else if (bus.busy) obs_raddr.push_back(bus.mem_addr);
                if (!bus.busy && (bus.mem_we || bus.mem_addr != '0 || bus.mem_wdata != '0))
                    obs_idle_err++;
                if (bus.done) begin
                    obs_done_cyc = cyc;
                    obs_fault = bus.fault;
                    obs_rdata = bus.rdata;
                end
            end else begin
                if (bus.done) obs_extra_done++;
                if (cyc >= obs_done_cyc + 2) break;
            end
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.write = 1'b0; bus.size = '0; bus.wdata = '0;
        bus.Byte0 = '0; bus.Byte1 = '0; bus.Byte2 = '0; bus.Byte3 = '0;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.rdata, bus.busy, bus.done, bus.fault, bus.mem_addr, bus.mem_wdata, bus.mem_we} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: rdata=%h busy=%b done=%b fault=%b addr=%h wd=%h we=%b, want all 0",
                     bus.rdata, bus.busy, bus.done, bus.fault, bus.mem_addr, bus.mem_wdata, bus.mem_we);
        end
        @(negedge clk) rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({bus.busy, bus.done, bus.mem_we} !== 3'b000) begin
                n_fail++;
                $display("FAIL idle_after_reset cyc%0d: busy/done/we=%b want 000", i, {bus.busy, bus.done, bus.mem_we});
            end
        end
    endtask

    task automatic test_word_store();
        op_wr = 1'b1; op_sz = 2'd2; op_wd = 32'hDEAD_BEEF;
        op_b[0] = 32'h2000; op_b[1] = 32'h1FFF; op_b[2] = 32'h1FFE; op_b[3] = 32'h1FFD;
        model_predict();
        observe_op(0);
        n_checks++; if (obs_done_cyc !== 5) begin n_fail++; $display("FAIL store_done_cycle: got %0d want 5", obs_done_cyc); end
        n_checks++; if (obs_fault !== 1'b0) begin n_fail++; $display("FAIL store_fault: got %b want 0", obs_fault); end
        n_checks++; if (obs_busy_cnt !== 4) begin n_fail++; $display("FAIL store_busy_cycles: got %0d want 4", obs_busy_cnt); end
        n_checks++; if (obs_idle_err !== 0) begin n_fail++; $display("FAIL store_idle_port: got %0d want 0", obs_idle_err); end
        n_checks++; if (obs_extra_done !== 0) begin n_fail++; $display("FAIL store_done_width: got %0d want 0", obs_extra_done); end
        n_checks++;
        if (obs_wlog.size() != exp_wlog.size()) begin
            n_fail++; $display("FAIL store_write_count: got %0d want %0d", obs_wlog.size(), exp_wlog.size());
        end else foreach (exp_wlog[i]) begin
            n_checks++;
            if (obs_wlog[i] !== exp_wlog[i]) begin n_fail++; $display("FAIL store_write%0d: got %h want %h", i, obs_wlog[i], exp_wlog[i]); end
        end
    endtask

    task automatic test_loads();
        op_wr = 1'b0; op_sz = 2'd2; op_wd = $urandom;
        model_predict();
        observe_op(0);
        n_checks++; if (obs_done_cyc !== 6) begin n_fail++; $display("FAIL wload_done_cycle: got %0d want 6", obs_done_cyc); end
        n_checks++; if (obs_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wload_rdata: got %h want deadbeef", obs_rdata); end
        n_checks++; if (obs_busy_cnt !== 5) begin n_fail++; $display("FAIL wload_busy_cycles: got %0d want 5", obs_busy_cnt); end
        n_checks++;
        if (obs_raddr.size() != exp_raddr.size()) begin
            n_fail++; $display("FAIL wload_read_count: got %0d want %0d", obs_raddr.size(), exp_raddr.size());
        end else foreach (exp_raddr[i]) begin
            n_checks++;
            if (obs_raddr[i] !== exp_raddr[i]) begin n_fail++; $display("FAIL wload_addr%0d: got %h want %h", i, obs_raddr[i], exp_raddr[i]); end
        end
        // Unused upper lanes may hold anything, even the empty-stack marker.
        op_sz = 2'd1; op_b[0] = 32'h2000; op_b[1] = 32'h1FFF; op_b[2] = $urandom; op_b[3] = 32'hFFFF_FFFF;
        model_predict();
        observe_op(0);
        n_checks++; if (obs_done_cyc !== 4) begin n_fail++; $display("FAIL hload_done_cycle: got %0d want 4", obs_done_cyc); end
        n_checks++; if (obs_fault !== 1'b0) begin n_fail++; $display("FAIL hload_fault: got %b want 0", obs_fault); end
        n_checks++; if (obs_rdata !== 32'h0000_BEEF) begin n_fail++; $display("FAIL hload_rdata: got %h want 0000beef", obs_rdata); end
    endtask

    task automatic test_byte_load_ignore_start();
        op_wr = 1'b1; op_sz = 2'd0; op_wd = 32'h0000_005A;
        op_b[0] = 32'h1800; op_b[1] = $urandom; op_b[2] = $urandom; op_b[3] = $urandom;
        model_predict();
        observe_op(0);
        n_checks++; if (obs_done_cyc !== 2) begin n_fail++; $display("FAIL bstore_done_cycle: got %0d want 2", obs_done_cyc); end
        op_wr = 1'b0; op_wd = $urandom;
        model_predict();
        observe_op(2);
        n_checks++; if (obs_done_cyc !== 3) begin n_fail++; $display("FAIL bload_done_cycle: got %0d want 3", obs_done_cyc); end
        n_checks++; if (obs_rdata !== 32'h0000_005A) begin n_fail++; $display("FAIL bload_rdata: got %h want 0000005a", obs_rdata); end
        n_checks++; if (obs_raddr.size() !== 2) begin n_fail++; $display("FAIL bload_read_count: got %0d want 2", obs_raddr.size()); end
        n_checks++; if (obs_extra_done !== 0) begin n_fail++; $display("FAIL bload_ignored_start: extra done %0d want 0", obs_extra_done); end
    endtask

    task automatic test_faults();
        for (int c = 0; c < 3; c++) begin
            op_wr = 1'($urandom_range(0, 1)); op_wd = $urandom;
            op_b[0] = 32'h10; op_b[1] = 32'h11; op_b[2] = 32'h12; op_b[3] = 32'h13;
            case (c)
                0: begin op_sz = 2'd0; op_b[0] = 32'hFFFF_FFFF; end
                1: begin op_sz = 2'd2; op_b[3] = 32'h4000; end
                default: op_sz = 2'd3;
            endcase
            model_predict();
            observe_op(0);
            n_checks++; if (obs_done_cyc !== 1) begin n_fail++; $display("FAIL fault%0d_done_cycle: got %0d want 1", c, obs_done_cyc); end
            n_checks++; if (obs_fault !== 1'b1) begin n_fail++; $display("FAIL fault%0d_flag: got %b want 1", c, obs_fault); end
            n_checks++; if (obs_wlog.size() !== 0) begin n_fail++; $display("FAIL fault%0d_writes: got %0d want 0", c, obs_wlog.size()); end
            n_checks++; if (obs_busy_cnt !== 0) begin n_fail++; $display("FAIL fault%0d_busy: got %0d want 0", c, obs_busy_cnt); end
            n_checks++; if (obs_rdata !== exp_rdata) begin n_fail++; $display("FAIL fault%0d_rdata: got %h want %h", c, obs_rdata, exp_rdata); end
        end
    endtask

    task automatic test_reset_mid_store();
        op_wr = 1'b1; op_sz = 2'd2; op_wd = 32'h1122_3344;
        op_b[0] = 32'h2000; op_b[1] = 32'h1FFF; op_b[2] = 32'h1FFE; op_b[3] = 32'h1FFD;
        drive_req();
        @(posedge clk); #1; bus.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_checks++; if (bus.mem_we !== 1'b1) begin n_fail++; $display("FAIL midrst_we_before: got %b want 1", bus.mem_we); end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.rdata, bus.busy, bus.done, bus.fault, bus.mem_addr, bus.mem_wdata, bus.mem_we} !== '0) begin
            n_fail++;
            $display("FAIL midrst_async: rdata=%h busy=%b done=%b fault=%b addr=%h wd=%h we=%b, want all 0",
                     bus.rdata, bus.busy, bus.done, bus.fault, bus.mem_addr, bus.mem_wdata, bus.mem_we);
        end
        exp_rdata = '0;
        ref_mem[32'h2000] = 8'h44;
        ref_mem[32'h1FFF] = 8'h33;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (i == 1) rst = 1'b0;
            n_checks++;
            if ({bus.done, bus.busy, bus.mem_we} !== 3'b000) begin
                n_fail++; $display("FAIL midrst_quiet%0d: done/busy/we=%b want 000", i, {bus.done, bus.busy, bus.mem_we});
            end
        end
        n_checks++; if (ram[14'h2000] !== 8'h44) begin n_fail++; $display("FAIL midrst_ram2000: got %h want 44", ram[14'h2000]); end
        n_checks++; if (ram[14'h1FFF] !== 8'h33) begin n_fail++; $display("FAIL midrst_ram1fff: got %h want 33", ram[14'h1FFF]); end
        n_checks++; if (ram[14'h1FFE] !== 8'hAD) begin n_fail++; $display("FAIL midrst_ram1ffe: got %h want ad", ram[14'h1FFE]); end
        n_checks++; if (ram[14'h1FFD] !== 8'hDE) begin n_fail++; $display("FAIL midrst_ram1ffd: got %h want de", ram[14'h1FFD]); end
        op_wd = $urandom;
        model_predict();
        observe_op(0);
        n_checks++; if (obs_done_cyc !== 5) begin n_fail++; $display("FAIL postrst_store_done: got %0d want 5", obs_done_cyc); end
        op_wr = 1'b0;
        model_predict();
        observe_op(0);
        n_checks++; if (obs_rdata !== op_wd) begin n_fail++; $display("FAIL postrst_load_rdata: got %h want %h", obs_rdata, op_wd); end
    endtask

    task automatic test_back_to_back();
        int c;
        op_wr = 1'b1; op_sz = 2'd2; op_wd = $urandom;
        op_b[0] = 32'h100; op_b[1] = 32'h101; op_b[2] = 32'h102; op_b[3] = 32'h103;
        model_predict();
        drive_req();
        for (c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            if (c == 1) bus.start = 1'b0;
            if (bus.done) break;
        end
        n_checks++; if (c !== 5) begin n_fail++; $display("FAIL b2b_store_done: got %0d want 5", c); end
        op_wr = 1'b0;
        model_predict();
        drive_req();
        @(posedge clk); #1; bus.start = 1'b0;
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept_in_fin: busy %b want 1", bus.busy); end
        c = 1;
        while (!bus.done && c < 12) begin
            @(posedge clk); #1;
            c++;
        end
        n_checks++; if (c !== 6) begin n_fail++; $display("FAIL b2b_load_done: got %0d want 6", c); end
        n_checks++; if (bus.rdata !== op_wd) begin n_fail++; $display("FAIL b2b_load_rdata: got %h want %h", bus.rdata, op_wd); end
        @(posedge clk); #1;
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL b2b_done_drop: got %b want 0", bus.done); end
    endtask

    task automatic test_random_ops();
        for (int t = 0; t < 60; t++) begin
            op_wr = 1'($urandom_range(0, 1));
            op_sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            for (int k = 0; k < 4; k++) op_b[k] = rand_addr();
            op_wd = $urandom;
            model_predict();
            observe_op(0);
            n_checks++; if (obs_done_cyc !== exp_lat) begin n_fail++; $display("FAIL rand%0d_latency: got %0d want %0d", t, obs_done_cyc, exp_lat); end
            n_checks++; if (obs_fault !== exp_fault) begin n_fail++; $display("FAIL rand%0d_fault: got %b want %b", t, obs_fault, exp_fault); end
            n_checks++; if (obs_rdata !== exp_rdata) begin n_fail++; $display("FAIL rand%0d_rdata: got %h want %h", t, obs_rdata, exp_rdata); end
            n_checks++; if (obs_idle_err !== 0) begin n_fail++; $display("FAIL rand%0d_idle_port: got %0d want 0", t, obs_idle_err); end
            n_checks++;
            if (obs_wlog.size() != exp_wlog.size()) begin
                n_fail++; $display("FAIL rand%0d_write_count: got %0d want %0d", t, obs_wlog.size(), exp_wlog.size());
            end else foreach (exp_wlog[i]) begin
                n_checks++;
                if (obs_wlog[i] !== exp_wlog[i]) begin n_fail++; $display("FAIL rand%0d_write%0d: got %h want %h", t, i, obs_wlog[i], exp_wlog[i]); end
            end
            n_checks++;
            if (!op_wr && obs_raddr.size() != exp_raddr.size()) begin
                n_fail++; $display("FAIL rand%0d_read_count: got %0d want %0d", t, obs_raddr.size(), exp_raddr.size());
            end
        end
    endtask

    initial begin
        test_reset();
        test_word_store();
        test_loads();
        test_byte_load_ignore_start();
        test_faults();
        test_reset_mid_store();
        test_back_to_back();
        test_random_ops();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
